i2c_cmd_translator: RTL and testbench
=====================================

# i2c_cmd_translator

Translates legacy-I2C transfer commands from the HCI command queue and bytes from the TX data queue into format-FIFO entries for `i2c_controller_fsm`. Each entry is a byte plus start/stop/read flags. After each command it returns a completion response with an error status. It sits between the HCI queues and the controller FSM's `fmt_*` inputs, and drives the controller's format-FIFO handshake directly.

## Interface
Parameters:
- `MaxReadChunk`, default 256: maximum bytes per `read_bytes` fmt entry. A byte value of 0 encodes 256.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `cmd_valid_i` in 1: command descriptor valid.
- `cmd_ready_o` out 1: command accepted.
- `cmd_addr_i` in 7: target static address.
- `cmd_rnw_i` in 1: 1 = read, 0 = write.
- `cmd_len_i` in 16: data length in bytes.
- `cmd_stop_i` in 1: issue STOP at end of transfer.
- `cmd_tid_i` in 4: transaction ID.
- `tx_valid_i` in 1: TX data byte valid.
- `tx_ready_o` out 1: TX data byte consumed.
- `tx_data_i` in 8: TX data byte.
- `fmt_valid_o` out 1: fmt entry valid.
- `fmt_ready_i` in 1: controller `fmt_fifo_rready_o`.
- `fmt_byte_o` out 8: fmt byte.
- `fmt_start_o` out 1: start before the byte.
- `fmt_stop_o` out 1: stop after the byte.
- `fmt_readb_o` out 1: byte is a read count.
- `fmt_rcont_o` out 1: ACK the final read byte.
- `fmt_nakok_o` out 1: NACK tolerated.
- `host_idle_i` in 1: controller idle.
- `event_nak_i` in 1: controller NACK event.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: response consumed.
- `resp_tid_o` out 4: echoed TID.
- `resp_err_o` out 2: 0 = OK, 1 = NACK, 2 = unsupported length.

## Operation
- State machine states: IDLE, ADDR, WDATA, RCHUNK, WAIT_IDLE, DRAIN, RESP.
- IDLE: `cmd_ready_o`=1. On `cmd_valid_i` the block latches addr, rnw, len, stop and tid, then moves to ADDR.
- ADDR: emits `fmt_byte_o`={addr,rnw} with `fmt_start_o`=1.
  - `fmt_stop_o` = cmd_stop && len==0.
  - On handshake: len==0 → WAIT_IDLE; rnw → RCHUNK; otherwise → WDATA.
- WDATA: pass-through.
  - `fmt_valid_o`=`tx_valid_i`, `tx_ready_o`=`fmt_ready_i`, `fmt_byte_o`=`tx_data_i`.
  - A 16-bit remaining counter decrements on each handshake.
  - `fmt_stop_o` = cmd_stop && remaining==1.
  - When the counter reaches 0 → WAIT_IDLE.
- RCHUNK: emits `fmt_readb_o`=1.
  - Byte is min(remaining, MaxReadChunk) mod 256.
  - `fmt_rcont_o`=1 when remaining > MaxReadChunk.
  - `fmt_stop_o` = cmd_stop on the last chunk.
  - On handshake, remaining -= chunk; remaining==0 → WAIT_IDLE.
- WAIT_IDLE: `fmt_valid_o`=0. The first cycle with `host_idle_i`=1 → RESP.
- `event_nak_i` in ADDR, WDATA, RCHUNK or WAIT_IDLE:
  - Sets a sticky err=1 and stops fmt issue.
  - Write with remaining>0 → DRAIN; otherwise → WAIT_IDLE.
- DRAIN: `tx_ready_o`=1 and `fmt_valid_o`=0. TX bytes are discarded until remaining==0, then → WAIT_IDLE.
- RESP: `resp_valid_o`=1 with tid/err held. On `resp_ready_i` → IDLE and err clears.
- `fmt_nakok_o` is always 0.

## Timing
- Reset values:
  - `cmd_ready_o`=0 during reset, then 1 in IDLE the cycle after deassertion.
  - `fmt_valid_o`, `tx_ready_o`, `resp_valid_o` = 0.
  - `fmt_byte_o`, all fmt flags, `resp_tid_o`, `resp_err_o` = 0.
- Command accept to first `fmt_valid_o`: 1 cycle.
- All fmt outputs are registered except WDATA `fmt_byte_o` and `fmt_valid_o`, which are combinational from the TX queue.
- fmt outputs stay stable while `fmt_valid_o`=1 and `fmt_ready_i`=0.
- WDATA sustains 1 byte per cycle.
- `event_nak_i` coincident with a handshake: the handshake completes and counts, then the NACK takes effect.
- `event_nak_i` in IDLE, DRAIN or RESP is ignored.
- Response appears 1 cycle after `host_idle_i` is sampled in WAIT_IDLE and holds until `resp_ready_i`. There is no back-to-back accept: IDLE is re-entered first.
- Reset mid-command drops all state; no response is produced.

## Configuration
- `I2C_CMD_READ_SPLIT_EN` defined: reads longer than MaxReadChunk are split into chunks as above.
- Undefined: a read with len > MaxReadChunk emits nothing, goes straight to RESP with err=2, and no address phase occurs. Reads ≤ MaxReadChunk are unaffected.

## Test plan
- Write addr 0x50, len 3, stop, TX 0xA1/0xB2/0xC3, `fmt_ready_i`=1 → fmt entries:
  - 0xA0 start=1 stop=0
  - 0xA1, 0xB2
  - 0xC3 stop=1
  - After `host_idle_i`: resp err=0 with tid echoed.
- Read addr 0x21, len 600, stop, split enabled → entries:
  - 0x43 start
  - readb 0x00 rcont=1
  - readb 0x00 rcont=1
  - readb 0x58 rcont=0 stop=1
  - Same command with split disabled → no fmt entries, resp err=2.
- Write len 4, `event_nak_i` pulsed after the address handshake → no further fmt entries, 4 TX bytes drained, resp err=1.
- Address-only write len 0 with stop → single entry 0xA0 with start=1 and stop=1, resp err=0.
- `fmt_ready_i` held low 5 cycles during RCHUNK → byte and flags stable throughout; reset asserted mid-WDATA → all outputs 0 next cycle, `cmd_ready_o`=1 after release.

Source files
------------

// File: rtl/i2c_cmd_translator_if.sv
// i2c_cmd_translator_if: command, TX, fmt-FIFO and response handshakes
// between the HCI queues, the translator and the controller FSM.
interface i2c_cmd_translator_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [6:0]  cmd_addr_i;
  logic        cmd_rnw_i;
  logic [15:0] cmd_len_i;
  logic        cmd_stop_i;
  logic [3:0]  cmd_tid_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [7:0]  tx_data_i;
  logic        fmt_valid_o;
  logic        fmt_ready_i;
  logic [7:0]  fmt_byte_o;
  logic        fmt_start_o;
  logic        fmt_stop_o;
  logic        fmt_readb_o;
  logic        fmt_rcont_o;
  logic        fmt_nakok_o;
  logic        host_idle_i;
  logic        event_nak_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [3:0]  resp_tid_o;
  logic [1:0]  resp_err_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_rnw_i, cmd_len_i,
    input  cmd_stop_i, cmd_tid_i,
    input  tx_valid_i, tx_data_i, fmt_ready_i,
    input  host_idle_i, event_nak_i, resp_ready_i,
    output cmd_ready_o, tx_ready_o,
    output fmt_valid_o, fmt_byte_o, fmt_start_o, fmt_stop_o,
    output fmt_readb_o, fmt_rcont_o, fmt_nakok_o,
    output resp_valid_o, resp_tid_o, resp_err_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_rnw_i, cmd_len_i,
    output cmd_stop_i, cmd_tid_i,
    output tx_valid_i, tx_data_i, fmt_ready_i,
    output host_idle_i, event_nak_i, resp_ready_i,
    input  cmd_ready_o, tx_ready_o,
    input  fmt_valid_o, fmt_byte_o, fmt_start_o, fmt_stop_o,
    input  fmt_readb_o, fmt_rcont_o, fmt_nakok_o,
    input  resp_valid_o, resp_tid_o, resp_err_o
  );
endinterface

// File: rtl/i2c_cmd_translator.sv
// i2c_cmd_translator: legacy-I2C HCI commands -> controller fmt-FIFO entries.
// Define I2C_CMD_READ_SPLIT_EN to split reads longer than MaxReadChunk.
module i2c_cmd_translator #(
  parameter int MaxReadChunk = 256
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  i2c_cmd_translator_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, RCHUNK, WAIT_IDLE, DRAIN, RESP
  } state_t;

  localparam logic [15:0] Mrc = 16'(MaxReadChunk);

  state_t      r_state;
  logic        r_cmd_ready;
  logic        r_rnw;
  logic        r_stop;
  logic [3:0]  r_tid;
  logic [15:0] r_rem;
  logic [1:0]  r_err;
  logic        r_resp_valid;
  logic        r_fmt_valid;
  logic [7:0]  r_fmt_byte;
  logic        r_fmt_start;
  logic        r_fmt_stop;
  logic        r_fmt_readb;
  logic        r_fmt_rcont;

  logic        w_wdata;
  logic        w_fmt_hs;
  logic        w_tx_hs;
  logic        w_too_long;
  logic [15:0] w_rd_chunk;
  logic [15:0] w_rd_left;
  logic [15:0] w_wr_left;
  logic [15:0] w_nak_left;

  function automatic logic [15:0] chunk_of(input logic [15:0] v);
    return (v > Mrc) ? Mrc : v;
  endfunction

  // {byte, rcont, stop} of the read-count entry for v bytes still to read
  function automatic logic [9:0] rd_entry(input logic [15:0] v,
                                          input logic       stop);
    logic [15:0] c;
    c = chunk_of(v);
    return {c[7:0], v > Mrc, stop && (v <= Mrc)};
  endfunction

  assign w_wdata    = (r_state == WDATA);
  assign w_fmt_hs   = r_fmt_valid && bus.fmt_ready_i;
  assign w_tx_hs    = bus.tx_valid_i && bus.fmt_ready_i;
  assign w_rd_chunk = chunk_of(r_rem);
  assign w_rd_left  = r_rem - w_rd_chunk;
  assign w_wr_left  = r_rem - 16'd1;
  assign w_nak_left = w_tx_hs ? w_wr_left : r_rem;

`ifdef I2C_CMD_READ_SPLIT_EN
  assign w_too_long = 1'b0;
`else
  assign w_too_long = bus.cmd_rnw_i && (bus.cmd_len_i > Mrc);
`endif

  assign bus.cmd_ready_o  = r_cmd_ready;
  assign bus.fmt_valid_o  = w_wdata ? bus.tx_valid_i : r_fmt_valid;
  assign bus.fmt_byte_o   = w_wdata ? bus.tx_data_i : r_fmt_byte;
  assign bus.fmt_start_o  = r_fmt_start;
  assign bus.fmt_stop_o   = r_fmt_stop;
  assign bus.fmt_readb_o  = r_fmt_readb;
  assign bus.fmt_rcont_o  = r_fmt_rcont;
  assign bus.fmt_nakok_o  = 1'b0;
  assign bus.tx_ready_o   = (w_wdata && bus.fmt_ready_i) ||
                            (r_state == DRAIN);
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_tid_o   = r_tid;
  assign bus.resp_err_o   = r_err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_cmd_ready  <= 1'b0;
      r_rnw        <= 1'b0;
      r_stop       <= 1'b0;
      r_tid        <= '0;
      r_rem        <= '0;
      r_err        <= '0;
      r_resp_valid <= 1'b0;
      {r_fmt_valid, r_fmt_byte, r_fmt_start,
       r_fmt_stop, r_fmt_readb, r_fmt_rcont} <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (r_cmd_ready && bus.cmd_valid_i) begin
            r_cmd_ready <= 1'b0;
            r_rnw       <= bus.cmd_rnw_i;
            r_stop      <= bus.cmd_stop_i;
            r_tid       <= bus.cmd_tid_i;
            r_rem       <= bus.cmd_len_i;
            if (w_too_long) begin
              r_err        <= 2'd2;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_fmt_valid <= 1'b1;
              r_fmt_byte  <= {bus.cmd_addr_i, bus.cmd_rnw_i};
              r_fmt_start <= 1'b1;
              r_fmt_stop  <= bus.cmd_stop_i && (bus.cmd_len_i == 16'd0);
              r_fmt_readb <= 1'b0;
              r_fmt_rcont <= 1'b0;
              r_state     <= ADDR;
            end
          end
        end
        ADDR: begin
          if (w_fmt_hs) begin
            r_fmt_start <= 1'b0;
            if (r_rem == 16'd0) begin
              {r_fmt_valid, r_fmt_byte, r_fmt_stop,
               r_fmt_readb, r_fmt_rcont} <= '0;
              r_state <= WAIT_IDLE;
            end else if (r_rnw) begin
              {r_fmt_byte, r_fmt_rcont, r_fmt_stop} <= rd_entry(r_rem, r_stop);
              r_fmt_readb <= 1'b1;
              r_state     <= RCHUNK;
            end else begin
              r_fmt_valid <= 1'b0;
              r_fmt_byte  <= '0;
              r_fmt_stop  <= r_stop && (r_rem == 16'd1);
              r_state     <= WDATA;
            end
          end
          if (bus.event_nak_i) begin
            r_err <= 2'd1;
            {r_fmt_valid, r_fmt_byte, r_fmt_start,
             r_fmt_stop, r_fmt_readb, r_fmt_rcont} <= '0;
            r_state <= (!r_rnw && r_rem != 16'd0) ? DRAIN : WAIT_IDLE;
          end
        end
        WDATA: begin
          if (w_tx_hs) begin
            r_rem      <= w_wr_left;
            r_fmt_stop <= r_stop && (w_wr_left == 16'd1);
            if (w_wr_left == 16'd0) begin
              r_fmt_stop <= 1'b0;
              r_state    <= WAIT_IDLE;
            end
          end
          if (bus.event_nak_i) begin
            r_err      <= 2'd1;
            r_fmt_stop <= 1'b0;
            r_state    <= (w_nak_left != 16'd0) ? DRAIN : WAIT_IDLE;
          end
        end
        RCHUNK: begin
          if (w_fmt_hs) begin
            r_rem <= w_rd_left;
            if (w_rd_left == 16'd0) begin
              {r_fmt_valid, r_fmt_byte, r_fmt_stop,
               r_fmt_readb, r_fmt_rcont} <= '0;
              r_state <= WAIT_IDLE;
            end else begin
              {r_fmt_byte, r_fmt_rcont, r_fmt_stop} <=
                rd_entry(w_rd_left, r_stop);
            end
          end
          if (bus.event_nak_i) begin
            r_err <= 2'd1;
            {r_fmt_valid, r_fmt_byte, r_fmt_stop,
             r_fmt_readb, r_fmt_rcont} <= '0;
            r_state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (bus.event_nak_i) r_err <= 2'd1;
          if (bus.host_idle_i) begin
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        DRAIN: begin
          if (bus.tx_valid_i) begin
            r_rem <= w_wr_left;
            if (w_wr_left == 16'd0) r_state <= WAIT_IDLE;
          end
        end
        RESP: begin
          if (bus.resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_err        <= '0;
            r_cmd_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cmd_translator.sv
// tb_i2c_cmd_translator: table vectors, corner sequences and randomized
// commands checked against a list-building model of the fmt stream.
module tb_i2c_cmd_translator;
  localparam int Mrc = 256;
  localparam bit Split =
`ifdef I2C_CMD_READ_SPLIT_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct packed {
    logic [7:0] b;
    logic       st;
    logic       sp;
    logic       rb;
    logic       rc;
    logic       nk;
  } ent_t;

  typedef struct {
    logic [6:0]  addr;
    logic        rnw;
    logic [15:0] len;
    logic        stop;
    logic [3:0]  tid;
    int          nfmt;
    logic [1:0]  err;
    ent_t        first;
    ent_t        last;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_cmd_translator_if bus();

  i2c_cmd_translator #(.MaxReadChunk(Mrc)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  ent_t       got_q[$];
  logic [5:0] resp_q[$];
  int         n_tx_taken = 0;

  ent_t       exp_q[$];
  logic [7:0] cur_data[$];
  logic [7:0] tx_q[$];
  int         n_tx_pop = 0;
  bit         auto_mode = 0;
  bit         tx_en = 1;
  int         n_chk = 0;
  int         n_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fmt_valid_o && bus.fmt_ready_i)
        got_q.push_back(ent_t'{bus.fmt_byte_o, bus.fmt_start_o,
                               bus.fmt_stop_o, bus.fmt_readb_o,
                               bus.fmt_rcont_o, bus.fmt_nakok_o});
      if (bus.tx_valid_i && bus.tx_ready_o) n_tx_taken++;
      if (bus.resp_valid_o && bus.resp_ready_i)
        resp_q.push_back({bus.resp_tid_o, bus.resp_err_o});
    end
  end

  function automatic ent_t mk(input logic [7:0] b, input logic st,
                              input logic sp, input logic rb,
                              input logic rc);
    return ent_t'{b, st, sp, rb, rc, 1'b0};
  endfunction

  function automatic logic [13:0] cur_out();
    return {bus.fmt_valid_o, bus.fmt_byte_o, bus.fmt_start_o,
            bus.fmt_stop_o, bus.fmt_readb_o, bus.fmt_rcont_o,
            bus.fmt_nakok_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    while (n_tx_pop < n_tx_taken) begin
      if (tx_q.size() > 0) tx_q.delete(0);
      n_tx_pop++;
    end
    bus.tx_valid_i = tx_en && (tx_q.size() > 0) &&
                     (!auto_mode || $urandom_range(3) != 0);
    bus.tx_data_i = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    if (auto_mode) begin
      bus.fmt_ready_i  = ($urandom_range(3) != 0);
      bus.host_idle_i  = ($urandom_range(2) == 0);
      bus.resp_ready_i = ($urandom_range(1) == 1);
    end
  endtask

  task automatic issue(input logic [6:0] a, input logic rnw,
                       input logic [15:0] len, input logic stop,
                       input logic [3:0] tid);
    bit ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      if (bus.cmd_ready_o) ok = 1;
      else tick();
    end
    chk("cmd_ready_wait", 32'(ok), 32'd1);
    bus.cmd_addr_i = a;
    bus.cmd_rnw_i  = rnw;
    bus.cmd_len_i  = len;
    bus.cmd_stop_i = stop;
    bus.cmd_tid_i  = tid;
    bus.cmd_valid_i = 1'b1;
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input int rbase, output logic [5:0] rsp);
    bit ok = 0;
    for (int k = 0; k < 5000 && !ok; k++) begin
      tick();
      if (resp_q.size() > rbase) ok = 1;
    end
    chk("resp_wait", 32'(ok), 32'd1);
    rsp = ok ? resp_q[rbase] : 6'h3f;
    tick();
  endtask

  task automatic run_cmd(input logic [6:0] a, input logic rnw,
                         input logic [15:0] len, input logic stop,
                         input logic [3:0] tid, output int fbase,
                         output logic [5:0] rsp);
    int rbase;
    fbase = got_q.size();
    rbase = resp_q.size();
    if (!rnw) foreach (cur_data[i]) tx_q.push_back(cur_data[i]);
    issue(a, rnw, len, stop, tid);
    wait_resp(rbase, rsp);
  endtask

  task automatic model(input logic [6:0] a, input logic rnw, input int len,
                       input logic stop, output logic [1:0] err);
    int rem;
    int c;
    exp_q.delete();
    err = 2'd0;
    if (rnw && len > Mrc && !Split) begin
      err = 2'd2;
      return;
    end
    exp_q.push_back(mk({a, rnw}, 1'b1, stop && len == 0, 1'b0, 1'b0));
    if (!rnw)
      for (int i = 0; i < len; i++)
        exp_q.push_back(mk(cur_data[i], 1'b0, stop && i == len - 1,
                           1'b0, 1'b0));
    rem = len;
    while (rnw && rem > 0) begin
      c = (rem > Mrc) ? Mrc : rem;
      exp_q.push_back(mk(8'(c % 256), 1'b0, stop && rem <= Mrc,
                         1'b1, rem > Mrc));
      rem -= c;
    end
  endtask

  task automatic cmp_model(input string tag, input int fbase,
                           input logic [5:0] rsp, input logic [3:0] tid,
                           input logic [1:0] err);
    int n;
    n = got_q.size() - fbase;
    chk({tag, "_nfmt"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk({tag, "_ent"}, 32'(got_q[fbase + i]), 32'(exp_q[i]));
    chk({tag, "_resp"}, 32'(rsp), 32'({tid, err}));
  endtask

  initial begin
    vec_t       vt[7];
    int         fb;
    int         rb;
    int         tk0;
    int         n;
    logic [5:0] rsp;
    logic [1:0] merr;
    logic [6:0] ra;
    logic       rr;
    logic [15:0] rl;
    logic       rs;
    logic [3:0] rt;

    vt[0] = '{7'h50, 1'b0, 16'd3, 1'b1, 4'd3, 4, 2'd0,
              mk(8'hA0, 1, 0, 0, 0), mk(8'hC3, 0, 1, 0, 0)};
    vt[1] = '{7'h50, 1'b0, 16'd0, 1'b1, 4'd5, 1, 2'd0,
              mk(8'hA0, 1, 1, 0, 0), mk(8'hA0, 1, 1, 0, 0)};
`ifdef I2C_CMD_READ_SPLIT_EN
    vt[2] = '{7'h21, 1'b1, 16'd600, 1'b1, 4'd7, 4, 2'd0,
              mk(8'h43, 1, 0, 0, 0), mk(8'h58, 0, 1, 1, 0)};
    vt[4] = '{7'h10, 1'b1, 16'd257, 1'b1, 4'd2, 3, 2'd0,
              mk(8'h21, 1, 0, 0, 0), mk(8'h01, 0, 1, 1, 0)};
`else
    vt[2] = '{7'h21, 1'b1, 16'd600, 1'b1, 4'd7, 0, 2'd2,
              mk(8'h00, 0, 0, 0, 0), mk(8'h00, 0, 0, 0, 0)};
    vt[4] = '{7'h10, 1'b1, 16'd257, 1'b1, 4'd2, 0, 2'd2,
              mk(8'h00, 0, 0, 0, 0), mk(8'h00, 0, 0, 0, 0)};
`endif
    vt[3] = '{7'h21, 1'b1, 16'd256, 1'b0, 4'd9, 2, 2'd0,
              mk(8'h43, 1, 0, 0, 0), mk(8'h00, 0, 0, 1, 0)};
    vt[5] = '{7'h7F, 1'b0, 16'd1, 1'b0, 4'd15, 2, 2'd0,
              mk(8'hFE, 1, 0, 0, 0), mk(8'hA1, 0, 0, 0, 0)};
    vt[6] = '{7'h33, 1'b1, 16'd1, 1'b1, 4'd0, 2, 2'd0,
              mk(8'h67, 1, 0, 0, 0), mk(8'h01, 0, 1, 1, 0)};

    bus.cmd_valid_i = 0; bus.cmd_addr_i = 0; bus.cmd_rnw_i = 0;
    bus.cmd_len_i = 0; bus.cmd_stop_i = 0; bus.cmd_tid_i = 0;
    bus.tx_valid_i = 0; bus.tx_data_i = 0; bus.fmt_ready_i = 0;
    bus.host_idle_i = 0; bus.event_nak_i = 0; bus.resp_ready_i = 0;

    repeat (3) tick();
    chk("rst_fmt", 32'(cur_out()), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("rst_tx_ready", 32'(bus.tx_ready_o), 32'd0);
    chk("rst_resp", 32'({bus.resp_valid_o, bus.resp_tid_o,
                         bus.resp_err_o}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);

    bus.fmt_ready_i = 1; bus.host_idle_i = 1; bus.resp_ready_i = 1;
    for (int v = 0; v < 7; v++) begin
      cur_data.delete();
      for (int i = 0; i < int'(vt[v].len) && !vt[v].rnw; i++)
        cur_data.push_back(8'hA1 + 8'(i * 17));
      run_cmd(vt[v].addr, vt[v].rnw, vt[v].len, vt[v].stop, vt[v].tid,
              fb, rsp);
      n = got_q.size() - fb;
      chk($sformatf("v%0d_nfmt", v), 32'(n), 32'(vt[v].nfmt));
      if (n > 0) begin
        chk($sformatf("v%0d_first", v), 32'(got_q[fb]),
            32'(vt[v].first));
        chk($sformatf("v%0d_last", v), 32'(got_q[fb + n - 1]),
            32'(vt[v].last));
      end
      chk($sformatf("v%0d_resp", v), 32'(rsp),
          32'({vt[v].tid, vt[v].err}));
      model(vt[v].addr, vt[v].rnw, int'(vt[v].len), vt[v].stop, merr);
      cmp_model($sformatf("v%0d_mdl", v), fb, rsp, vt[v].tid, merr);
    end

    // NACK after address phase: remaining write bytes are drained
    bus.host_idle_i = 0; tx_en = 0;
    cur_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (cur_data[i]) tx_q.push_back(cur_data[i]);
    fb = got_q.size(); rb = resp_q.size(); tk0 = n_tx_taken;
    issue(7'h50, 1'b0, 16'd4, 1'b1, 4'd6);
    chk("lat_first_fmt", 32'(cur_out()),
        32'({1'b1, mk(8'hA0, 1, 0, 0, 0)}));
    tick();
    bus.event_nak_i = 1;
    tick();
    bus.event_nak_i = 0;
    tx_en = 1;
    repeat (12) tick();
    chk("nak_nfmt", 32'(got_q.size() - fb), 32'd1);
    chk("nak_drained", 32'(n_tx_taken - tk0), 32'd4);
    chk("nak_tx_left", 32'(tx_q.size()), 32'd0);
    bus.host_idle_i = 1;
    wait_resp(rb, rsp);
    chk("nak_resp", 32'(rsp), 32'({4'd6, 2'd1}));

    // a NACK seen in IDLE does not leak into the next command
    bus.event_nak_i = 1;
    tick();
    bus.event_nak_i = 0;
    cur_data.delete();
    run_cmd(7'h50, 1'b0, 16'd0, 1'b1, 4'd11, fb, rsp);
    chk("idle_nak_resp", 32'(rsp), 32'({4'd11, 2'd0}));
    chk("idle_nak_ent", 32'(got_q[fb]), 32'(mk(8'hA0, 1, 1, 0, 0)));

    // read-count entry held stable under back-pressure
    bus.host_idle_i = 0;
    fb = got_q.size(); rb = resp_q.size();
    issue(7'h21, 1'b1, 16'd200, 1'b1, 4'd4);
    tick();
    bus.fmt_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", 32'(cur_out()),
          32'({1'b1, mk(8'hC8, 0, 1, 1, 0)}));
      tick();
    end
    bus.fmt_ready_i = 1;
    tick();
    bus.host_idle_i = 1;
    wait_resp(rb, rsp);
    chk("stall_nfmt", 32'(got_q.size() - fb), 32'd2);
    chk("stall_resp", 32'(rsp), 32'({4'd4, 2'd0}));

    // reset in the middle of a write: no response afterwards
    bus.host_idle_i = 0;
    cur_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    foreach (cur_data[i]) tx_q.push_back(cur_data[i]);
    issue(7'h55, 1'b0, 16'd5, 1'b1, 4'd9);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_fmt", 32'(cur_out()), 32'd0);
    chk("mrst_tx_ready", 32'(bus.tx_ready_o), 32'd0);
    chk("mrst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("mrst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    tx_q.delete();
    n_tx_pop = n_tx_taken;
    rst_n = 1'b1;
    rb = resp_q.size();
    bus.host_idle_i = 1;
    tick();
    chk("mrst_cmd_ready_rel", 32'(bus.cmd_ready_o), 32'd1);
    repeat (5) tick();
    chk("mrst_no_resp", 32'(resp_q.size() - rb), 32'd0);

    auto_mode = 1;
    for (int t = 0; t < 40; t++) begin
      ra = 7'($urandom);
      rr = 1'($urandom);
      rs = 1'($urandom);
      rt = 4'($urandom);
      if (rr)
        rl = ($urandom_range(3) == 0) ? 16'($urandom_range(250, 600))
                                      : 16'($urandom_range(0, 6));
      else
        rl = 16'($urandom_range(0, 12));
      cur_data.delete();
      for (int i = 0; i < int'(rl) && !rr; i++)
        cur_data.push_back(8'($urandom));
      model(ra, rr, int'(rl), rs, merr);
      run_cmd(ra, rr, rl, rs, rt, fb, rsp);
      cmp_model($sformatf("rnd%0d", t), fb, rsp, rt, merr);
      if (!rr) chk($sformatf("rnd%0d_tx_left", t), 32'(tx_q.size()), 32'd0);
    end
    auto_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
